// File: rtl/uart_tx_fifo_if.sv
// Rib bus write/read channel between the bus fabric and the UART transmit peripheral.
// The master drives strobe, address and write data; the slave returns combinational read data.
`timescale 1ns/1ps
interface uart_tx_fifo_if;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output we_i, output addr_i, output data_i, input data_o);
   modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit peripheral: a byte FIFO written over the rib bus, drained by an 8N1 serializer.
// Back-to-back frames run without an idle gap while the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_fifo_if.slave    bus,
   output logic             tx_pin
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty;
   logic        push_req, push, pop;
   logic        status_wr, baud_wr;
   logic        ovf, busy;
   logic [15:0] baud_div, div_q, baud_cnt, baud_new;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        bit_done;
   logic [3:0]  offset;
   logic        unused_bits;

   assign offset      = bus.addr_i[3:0];
   assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[31:16]};

   // The extra wrap bit distinguishes a full FIFO from an empty one when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign push_req  = bus.we_i && (offset == 4'h0);
   assign status_wr = bus.we_i && (offset == 4'h4);
   assign baud_wr   = bus.we_i && (offset == 4'h8);
   assign push      = push_req && (!full || pop);
   assign baud_new  = (bus.data_i[15:0] < 16'd2) ? 16'd2 : bus.data_i[15:0];

   assign bit_done = (baud_cnt == div_q - 16'd1);
   assign busy     = (state != IDLE);

   // Next-state and line drive; a pop happens on leaving IDLE or finishing STOP with data queued.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tx_pin    = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx_pin = 1'b0;
            if (bit_done) state_nxt = DATA;
         end
         DATA: begin
            tx_pin = shreg[0];
            if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
         end
         STOP: begin
            if (bit_done) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.data_i[7:0];
   end

   // Pointers, sticky overflow, divisor register and the bit-timing datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf      <= 1'b0;
         baud_div <= BAUD_DIV_RST;
         div_q    <= BAUD_DIV_RST;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= 8'hFF;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push_req && !push) ovf <= 1'b1;
         else if (status_wr)    ovf <= 1'b0;
         if (baud_wr) baud_div <= baud_new;
         // The divisor is sampled only at frame start so a mid-frame write cannot distort a frame.
         if (pop) begin
            shreg    <= mem[rd_ptr[AW-1:0]];
            div_q    <= baud_div;
            baud_cnt <= '0;
            bit_idx  <= '0;
         end else if (state != IDLE) begin
            if (bit_done) begin
               baud_cnt <= '0;
               if (state == DATA) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end else begin
               baud_cnt <= baud_cnt + 16'd1;
            end
         end
      end
   end

   always_comb begin
      bus.data_o = '0;
      case (offset)
         4'h4:    bus.data_o = {28'b0, ovf, empty, full, busy};
         4'h8:    bus.data_o = {16'b0, baud_div};
         default: bus.data_o = '0;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: register map, frame timing, back-to-back frames, overflow and reset.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   int   testCount = 0;
   int   failCount = 0;

   uart_tx_fifo_if bus();

   uart_tx_fifo #(.FIFO_DEPTH(16), .BAUD_DIV_RST(16'd434)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .tx_pin (tx)
   );

   always #5 clk = ~clk;

   // Write schedule and expected byte stream used by applyStimulus; cycle c is the c-th negedge.
   logic [7:0]  wrData   [0:63];
   bit          wrEn     [0:63];
   logic [7:0]  expBytes [0:31];
   int          nExp;
   int          probeCycle;
   logic [31:0] probeStatus;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic readReg(input logic [3:0] a, output logic [31:0] v);
      @(negedge clk);
      bus.we_i   = 1'b0;
      bus.addr_i = {28'b0, a};
      #1 v = bus.data_o;
   endtask

   task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.we_i   = 1'b1;
      bus.addr_i = {28'b0, a};
      bus.data_i = d;
      @(negedge clk);
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h4;
   endtask

   task automatic clearSchedule();
      for (int i = 0; i < 64; i++) wrEn[i] = 1'b0;
      nExp       = 0;
      probeCycle = -1;
   endtask

   // Drives the scheduled TXDATA writes and checks tx_pin and busy on every cycle against
   // the 8N1 waveform (div=4) of expBytes, which starts two negedges after the first write.
   task automatic applyStimulus(input int cycles);
      int   off;
      int   k;
      logic expTx;
      logic expBusy;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (c < 2 || c >= 2 + 40 * nExp) begin
            expTx   = 1'b1;
            expBusy = 1'b0;
         end else begin
            off     = c - 2;
            k       = (off % 40) / 4;
            expBusy = 1'b1;
            if (k == 0)      expTx = 1'b0;
            else if (k == 9) expTx = 1'b1;
            else             expTx = expBytes[off / 40][k - 1];
         end
         checkOutput("tx_pin", {31'b0, tx}, {31'b0, expTx});
         if (c < 64 && wrEn[c]) begin
            bus.we_i   = 1'b1;
            bus.addr_i = 32'h0;
            bus.data_i = {24'b0, wrData[c]};
         end else begin
            bus.we_i   = 1'b0;
            bus.addr_i = 32'h4;
            #1;
            checkOutput("busy", {31'b0, bus.data_o[0]}, {31'b0, expBusy});
            if (c == probeCycle) checkOutput("status_probe", bus.data_o, probeStatus);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  digits [0:9];
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h0;
      bus.data_i = 32'h0;
      clearSchedule();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_tx", {31'b0, tx}, 32'h1);
      readReg(4'h4, v); checkOutput("rst_status", v, 32'h4);
      readReg(4'h8, v); checkOutput("rst_baud", v, 32'd434);
      readReg(4'h0, v); checkOutput("txdata_read", v, 32'h0);
      readReg(4'hC, v); checkOutput("unmapped_read", v, 32'h0);
      writeReg(4'h8, 32'h1);
      readReg(4'h8, v); checkOutput("baud_min_clamp", v, 32'h2);
      writeReg(4'hC, 32'h55);
      readReg(4'h4, v); checkOutput("unmapped_write", v, 32'h4);

      // Single frame of 0x32 at div=4
      writeReg(4'h8, 32'h4);
      readReg(4'h8, v); checkOutput("baud_set", v, 32'h4);
      clearSchedule();
      wrEn[0] = 1'b1; wrData[0] = 8'h32;
      expBytes[0] = 8'h32; nExp = 1;
      applyStimulus(45);
      readReg(4'h4, v); checkOutput("single_done_status", v, 32'h4);

      // Ten back-to-back writes of "2023310655"
      digits = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};
      clearSchedule();
      for (int i = 0; i < 10; i++) begin
         wrEn[i] = 1'b1; wrData[i] = digits[i]; expBytes[i] = digits[i];
      end
      nExp = 10;
      applyStimulus(405);
      readReg(4'h4, v); checkOutput("burst10_status", v, 32'h4);

      // Eighteen writes: the last finds the FIFO full and is dropped
      clearSchedule();
      for (int i = 0; i < 18; i++) begin
         wrEn[i] = 1'b1; wrData[i] = 8'(i);
      end
      for (int i = 0; i < 17; i++) expBytes[i] = 8'(i);
      nExp = 17;
      applyStimulus(685);
      readReg(4'h4, v); checkOutput("overflow_status", v, 32'hC);
      writeReg(4'h4, 32'h0);
      readReg(4'h4, v); checkOutput("ovf_cleared", v, 32'h4);

      // Full FIFO: a write lands in the same cycle as the STOP-end pop
      clearSchedule();
      for (int i = 0; i < 17; i++) begin
         wrEn[i] = 1'b1; wrData[i] = 8'h40 + 8'(i); expBytes[i] = 8'h40 + 8'(i);
      end
      wrEn[41] = 1'b1; wrData[41] = 8'h60; expBytes[17] = 8'h60;
      nExp        = 18;
      probeCycle  = 42;
      probeStatus = 32'h3;
      applyStimulus(725);
      readReg(4'h4, v); checkOutput("full_pop_push_status", v, 32'h4);

      // Reset in DATA bit 3 of 0xA5 (bit 3 is 0), then a clean frame
      @(negedge clk);
      bus.we_i   = 1'b1;
      bus.addr_i = 32'h0;
      bus.data_i = 32'hA5;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         bus.we_i   = 1'b0;
         bus.addr_i = 32'h4;
      end
      checkOutput("mid_frame_bit3", {31'b0, tx}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("post_reset_tx", {31'b0, tx}, 32'h1);
      #1 checkOutput("post_reset_status", bus.data_o, 32'h4);
      readReg(4'h8, v); checkOutput("post_reset_baud", v, 32'd434);
      writeReg(4'h8, 32'h4);
      clearSchedule();
      wrEn[0] = 1'b1; wrData[0] = 8'h5A;
      expBytes[0] = 8'h5A; nExp = 1;
      applyStimulus(45);
      readReg(4'h4, v); checkOutput("post_reset_frame_status", v, 32'h4);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
